// File: rtl/audio_echo.sv
// Stereo echo stage: one delay line per channel held in a single interleaved
// block RAM (even address = left, odd = right). Each codec frame runs a fixed
// read/compute/write schedule. The DAC words are updated seven cycles after the
// frame strobe's rising edge.
module audio_echo #(
  parameter int ADDR_W   = 9,
  parameter int SAMPLE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       LCH_ADC,
  input  logic [23:0]       RCH_ADC,
  input  logic              ADC_Update,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [7:0]        fb_gain,
  input  logic [7:0]        wet_gain,
  output logic [23:0]       LCH_DAC,
  output logic [23:0]       RCH_DAC,
  output logic              DAC_Update,
  output logic              busy,
  output logic              overrun
);

  localparam int MEM_D = 2 ** (ADDR_W + 1);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_RD_L  = 3'd2;
  localparam logic [2:0] S_RD_R  = 3'd3;
  localparam logic [2:0] S_CAP_R = 3'd4;
  localparam logic [2:0] S_WR_L  = 3'd5;
  localparam logic [2:0] S_WR_R  = 3'd6;
  localparam logic [2:0] S_OUT   = 3'd7;

  logic [2:0]          state;
  logic                upd_q;
  logic                evt;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     clr_addr;
  logic [SAMPLE_W-1:0] x_l, x_r, d_l, d_r;
  logic [SAMPLE_W-1:0] y_l, y_r, s_l, s_r;
  logic                d_zero;
  logic [7:0]          fb_q, wet_q;

  logic [SAMPLE_W-1:0] mem [MEM_D];
  logic                ram_we;
  logic [ADDR_W:0]     ram_addr;
  logic [SAMPLE_W-1:0] ram_wd, ram_rd;

  assign evt  = ADC_Update & ~upd_q;
  assign busy = (state != S_IDLE);
  // A zero delay would read the slot about to be overwritten; force a dry path.
  assign d_r  = d_zero ? '0 : ram_rd;

  // sat(x + ((d * g) >>> 8)), all signed; the shift floors toward -inf.
  function automatic logic [SAMPLE_W-1:0] mix(input logic [SAMPLE_W-1:0] x,
                                              input logic [SAMPLE_W-1:0] d,
                                              input logic [7:0]          g);
    logic signed [SAMPLE_W+8:0] prod;
    logic        [SAMPLE_W:0]   p;
    logic        [SAMPLE_W+1:0] sum;
    prod = $signed({{9{d[SAMPLE_W-1]}}, d}) * $signed({{SAMPLE_W{1'b0}}, 1'b0, g});
    p    = prod[SAMPLE_W+8:8];
    sum  = {{2{x[SAMPLE_W-1]}}, x} + {p[SAMPLE_W], p};
    if (sum[SAMPLE_W+1:SAMPLE_W-1] == 3'b000 || sum[SAMPLE_W+1:SAMPLE_W-1] == 3'b111)
      mix = sum[SAMPLE_W-1:0];
    else if (sum[SAMPLE_W+1])
      mix = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      mix = {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  // RAM port steering: clear sweep, reads of the delayed pair, writes of the new pair.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wd   = '0;
    case (state)
      S_CLEAR: begin ram_we = 1'b1; ram_addr = clr_addr; end
      S_RD_L:  ram_addr = {rd_ptr, 1'b0};
      S_RD_R:  ram_addr = {rd_ptr, 1'b1};
      S_WR_L:  begin ram_we = 1'b1; ram_addr = {wr_ptr, 1'b0}; ram_wd = s_l; end
      S_WR_R:  begin ram_we = 1'b1; ram_addr = {wr_ptr, 1'b1}; ram_wd = s_r; end
      default: ;
    endcase
  end

  // Block RAM with registered read data.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    ram_rd <= mem[ram_addr];
  end

  // Frame sequencer, pointers, outputs and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CLEAR;
      clr_addr   <= '0;
      wr_ptr     <= '0;
      upd_q      <= 1'b0;
      LCH_DAC    <= '0;
      RCH_DAC    <= '0;
      DAC_Update <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      upd_q      <= ADC_Update;
      DAC_Update <= 1'b0;
      if (evt && state != S_IDLE && state != S_CLEAR) overrun <= 1'b1;
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) state <= S_IDLE;
        end
        S_IDLE:  if (evt) state <= S_RD_L;
        S_RD_L:  state <= S_RD_R;
        S_RD_R:  state <= S_CAP_R;
        S_CAP_R: state <= S_WR_L;
        S_WR_L:  state <= S_WR_R;
        S_WR_R: begin
          wr_ptr <= wr_ptr + 1'b1;
          state  <= S_OUT;
        end
        default: begin
          LCH_DAC    <= {y_l, {(24-SAMPLE_W){1'b0}}};
          RCH_DAC    <= {y_r, {(24-SAMPLE_W){1'b0}}};
          DAC_Update <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: latch frame inputs at the strobe, capture delayed samples, mix.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && evt) begin
      x_l    <= LCH_ADC[23 -: SAMPLE_W];
      x_r    <= RCH_ADC[23 -: SAMPLE_W];
      rd_ptr <= wr_ptr - delay_len;
      d_zero <= (delay_len == '0);
      fb_q   <= fb_gain;
      wet_q  <= wet_gain;
    end
    if (state == S_RD_R) d_l <= d_zero ? '0 : ram_rd;
    if (state == S_CAP_R) begin
      y_l <= mix(x_l, d_l, wet_q);
      s_l <= mix(x_l, d_l, fb_q);
      y_r <= mix(x_r, d_r, wet_q);
      s_r <= mix(x_r, d_r, fb_q);
    end
  end

endmodule
